// File: rtl/delay_line_scheduler_if.sv
// delay_line_scheduler_if: port bundle between the scheduler and its shared block RAM.
interface delay_line_scheduler_if #(
    parameter int ADDR_BITS   = 8,
    parameter int SAMPLE_BITS = 12
);
    logic [ADDR_BITS-1:0]   waddr;
    logic [SAMPLE_BITS-1:0] wdata;
    logic                   we;
    logic [ADDR_BITS-1:0]   raddr;
    logic                   re;
    logic [SAMPLE_BITS-1:0] rdata;

    modport master (output waddr, wdata, we, raddr, re, input rdata);
    modport slave  (input waddr, wdata, we, raddr, re, output rdata);
endinterface

// File: rtl/delay_line_scheduler.sv
// delay_line_scheduler: shares one block RAM between per-channel delay lines, one write and tap read per channel per tick.
// Defining DELAY_SCHED_MIX_EN outputs (dry + delayed) / 2 instead of the raw delayed tap.
module delay_line_scheduler #(
    parameter int NUM_CHANNELS = 2,
    parameter int CH_BITS      = 1,
    parameter int ADDR_BITS    = 8,
    parameter int SAMPLE_BITS  = 12
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          sample_tick,
    input  logic [NUM_CHANNELS*SAMPLE_BITS-1:0]           din,
    input  logic [NUM_CHANNELS*(ADDR_BITS-CH_BITS)-1:0]   tap,
    output logic [NUM_CHANNELS*SAMPLE_BITS-1:0]           dout,
    output logic                                          done,
    output logic                                          busy,
    output logic                                          overrun,
    delay_line_scheduler_if.master                        ram
);
    localparam int P_BITS = ADDR_BITS - CH_BITS;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t                         state;
    logic [CH_BITS-1:0]             ch, nch;
    logic [P_BITS-1:0]              wptr, itap;
    logic                           filled;
    logic signed [SAMPLE_BITS-1:0]  din_snap [NUM_CHANNELS];
    logic [P_BITS-1:0]              tap_snap [NUM_CHANNELS];
    logic signed [SAMPLE_BITS-1:0]  shadow   [NUM_CHANNELS];
    logic signed [SAMPLE_BITS-1:0]  sel      [NUM_CHANNELS];
    logic signed [SAMPLE_BITS-1:0]  nxt_out  [NUM_CHANNELS];
    logic signed [SAMPLE_BITS-1:0]  cap, idin;
`ifdef DELAY_SCHED_MIX_EN
    logic signed [SAMPLE_BITS:0]    sum      [NUM_CHANNELS];
`endif

    // Issue operands: channel 0 straight from the ports on the tick, later channels from the snapshot.
    always_comb begin
        nch  = state == IDLE ? '0 : ch + CH_BITS'(1);
        idin = state == IDLE ? din[0 +: SAMPLE_BITS] : din_snap[nch];
        itap = state == IDLE ? tap[0 +: P_BITS] : tap_snap[nch];
        cap  = tap_snap[ch] == '0 ? din_snap[ch] :
               (!filled && tap_snap[ch] > wptr) ? '0 : ram.rdata;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sel[c] = c == NUM_CHANNELS - 1 ? cap : shadow[c];
`ifdef DELAY_SCHED_MIX_EN
            sum[c]     = {sel[c][SAMPLE_BITS-1], sel[c]} + {din_snap[c][SAMPLE_BITS-1], din_snap[c]};
            nxt_out[c] = sum[c][SAMPLE_BITS:1];
`else
            nxt_out[c] = sel[c];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch        <= '0;
            wptr      <= '0;
            filled    <= 1'b0;
            dout      <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            ram.waddr <= '0;
            ram.wdata <= '0;
            ram.we    <= 1'b0;
            ram.raddr <= '0;
            ram.re    <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                din_snap[c] <= '0;
                tap_snap[c] <= '0;
                shadow[c]   <= '0;
            end
        end else begin
            done   <= 1'b0;
            ram.we <= 1'b0;
            ram.re <= 1'b0;
            if (sample_tick && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (sample_tick) begin
                    for (int c = 0; c < NUM_CHANNELS; c++) begin
                        din_snap[c] <= din[c*SAMPLE_BITS +: SAMPLE_BITS];
                        tap_snap[c] <= tap[c*P_BITS +: P_BITS];
                    end
                    ch        <= nch;
                    busy      <= 1'b1;
                    ram.we    <= 1'b1;
                    ram.re    <= 1'b1;
                    ram.waddr <= {nch, wptr};
                    ram.wdata <= idin;
                    ram.raddr <= {nch, wptr - itap};
                    state     <= ISSUE;
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    shadow[ch] <= cap;
                    if (ch == CH_BITS'(NUM_CHANNELS - 1)) begin
                        for (int c = 0; c < NUM_CHANNELS; c++)
                            dout[c*SAMPLE_BITS +: SAMPLE_BITS] <= nxt_out[c];
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        ch        <= nch;
                        ram.we    <= 1'b1;
                        ram.re    <= 1'b1;
                        ram.waddr <= {nch, wptr};
                        ram.wdata <= idin;
                        ram.raddr <= {nch, wptr - itap};
                        state     <= ISSUE;
                    end
                end
                DONE: begin
                    wptr  <= wptr + P_BITS'(1);
                    if (&wptr)
                        filled <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_delay_line_scheduler.sv
// tb_delay_line_scheduler: randomized scoreboard bench with a history-based delay-line model and a behavioural RAM.
module tb_delay_line_scheduler;
    localparam int N  = 2;
    localparam int CB = 1;
    localparam int AB = 8;
    localparam int SB = 12;
    localparam int PB = AB - CB;
    localparam int D  = 2**PB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_tick = 1'b0;
    logic [N*SB-1:0] din = '0;
    logic [N*PB-1:0] tap = '0;
    logic [N*SB-1:0] dout;
    logic          done, busy, overrun;

    delay_line_scheduler_if #(.ADDR_BITS(AB), .SAMPLE_BITS(SB)) ram ();

    delay_line_scheduler #(.NUM_CHANNELS(N), .CH_BITS(CB), .ADDR_BITS(AB), .SAMPLE_BITS(SB)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .din(din), .tap(tap),
        .dout(dout), .done(done), .busy(busy), .overrun(overrun), .ram(ram)
    );

    always #5 clk = ~clk;

    logic [SB-1:0] mem [2**AB];
    always @(posedge clk) begin
        if (ram.we) mem[ram.waddr] <= ram.wdata;
        if (ram.re) ram.rdata <= mem[ram.raddr];
    end

    typedef struct {
        int t0;
        int wp;
        int tp [N];
        int dv [N];
        int ex [N];
    } exp_t;

    exp_t q [$];
    int   cyc = 0;
    int   k = 0;
    int   hist [N][1024];
    int   checks = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int rnd_s();
        logic signed [SB-1:0] r;
        r = SB'($urandom);
        return int'(r);
    endfunction

    // Expected output: the sample written tap ticks ago, zero if no such tick since reset.
    task automatic tick_go(input int d0, input int d1, input int p0, input int p1, input bit wait_done);
        exp_t e;
        int dv [N];
        int tp [N];
        int x;
        dv = '{d0, d1};
        tp = '{p0, p1};
        @(posedge clk); #1;
        for (int c = 0; c < N; c++) begin
            din[c*SB +: SB] = SB'(dv[c]);
            tap[c*PB +: PB] = PB'(tp[c]);
        end
        sample_tick = 1'b1;
        e.t0 = cyc;
        e.wp = k % D;
        for (int c = 0; c < N; c++) begin
            x = tp[c] == 0 ? dv[c] : (k >= tp[c] ? hist[c][k - tp[c]] : 0);
`ifdef DELAY_SCHED_MIX_EN
            x = (dv[c] + x) >>> 1;
`endif
            e.tp[c] = tp[c];
            e.dv[c] = dv[c];
            e.ex[c] = x;
            hist[c][k] = dv[c];
        end
        k++;
        q.push_back(e);
        @(posedge clk); #1;
        sample_tick = 1'b0;
        din = (N*SB)'($urandom);
        tap = (N*PB)'($urandom);
        if (wait_done) wait_idle();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sequence_complete_pending", q.size(), 0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        k = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        int off, c;
        if (rst_n) begin
            if (ram.we || ram.re) begin
                if (q.size() == 0) chk("issue_without_tick", 1, 0);
                else begin
                    e   = q[0];
                    off = cyc - e.t0 - 1;
                    c   = off / 2;
                    chk("issue_in_window", int'(off >= 0 && off < 2*N && off % 2 == 0), 1);
                    if (off >= 0 && off < 2*N) begin
                        chk("we_re_together", int'({ram.we, ram.re}), 3);
                        chk("ram_waddr", int'(ram.waddr), c*D + e.wp);
                        chk("ram_raddr", int'(ram.raddr), c*D + (e.wp - e.tp[c] + D) % D);
                        chk("raddr_partition", int'(ram.raddr[AB-1]), c);
                        chk("ram_wdata", int'($signed(ram.wdata)), e.dv[c]);
                    end
                end
            end
            if (done) begin
                if (q.size() == 0) chk("done_without_tick", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("done_latency", cyc - e.t0, 1 + 2*N);
                    for (int i = 0; i < N; i++)
                        chk($sformatf("dout%0d", i), int'($signed(dout[i*SB +: SB])), e.ex[i]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dout", int'(dout), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_overrun", int'(overrun), 0);
        chk("reset_we", int'(ram.we), 0);
        chk("reset_re", int'(ram.re), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) tick_go(i, rnd_s(), 5, $urandom_range(0, D-1), 1'b1);
        for (int i = 0; i < 4; i++)  tick_go(rnd_s(), -100, $urandom_range(0, D-1), 0, 1'b1);

        do_reset();
        for (int i = 0; i < 200; i++) tick_go(i, 'h7FF, 127, 127, 1'b1);
        for (int i = 0; i < 60; i++)
            tick_go(rnd_s(), rnd_s(), $urandom_range(0, D-1), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, D-1), 1'b1);

        chk("overrun_before", int'(overrun), 0);
        tick_go(rnd_s(), rnd_s(), $urandom_range(0, D-1), $urandom_range(0, D-1), 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_mid_sequence", int'(busy), 1);
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(posedge clk); #1;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        wait_idle();
        chk("overrun_sticky", int'(overrun), 1);
        for (int i = 0; i < 5; i++) tick_go(rnd_s(), rnd_s(), $urandom_range(0, 20), $urandom_range(0, 20), 1'b1);

        tick_go(rnd_s(), rnd_s(), 3, 4, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        k = 0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_dout", int'(dout), 0);
        chk("abort_overrun", int'(overrun), 0);
        chk("abort_we", int'(ram.we), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        for (int i = 0; i < 10; i++) tick_go(rnd_s(), rnd_s(), $urandom_range(0, 8), $urandom_range(0, 8), 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
